// File: rtl/tl_phase_sched.sv
// Phase scheduler for a two-road intersection with protected left turns.
// Four phases (A through, A left, B through, B left) are served round-robin
// on demand. Minimum green, maximum green, yellow and all-red clearance
// times are enforced, and the La/Lb light codes are decoded from the state.
module tl_phase_sched #(
    parameter int unsigned TW        = 5,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 16,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [1:0] phase,
    output logic       phase_start
);

    // Light encodings shared by both approaches.
    localparam logic [1:0] LightGreen  = 2'b00;
    localparam logic [1:0] LightYellow = 2'b01;
    localparam logic [1:0] LightLeft   = 2'b10;
    localparam logic [1:0] LightRed    = 2'b11;

    // Thresholds resized to the timer width so comparisons stay width-matched.
    localparam logic [TW-1:0] MinGreenT = TW'(MIN_GREEN);
    localparam logic [TW-1:0] MaxGreenT = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YellowT   = TW'(YELLOW_T);
    localparam logic [TW-1:0] AllRedT   = TW'(ALLRED_T);
    localparam logic [TW-1:0] TimerOne  = TW'(1);
    localparam logic [TW-1:0] TimerMax  = {TW{1'b1}};

    typedef enum logic [1:0] {
        StAllRed = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2
    } state_e;

    state_e        fsm_q, fsm_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0] demand;
    logic       own_demand;
    logic       other_demand;
    logic       grant_vld;
    logic [1:0] grant;

    // Demand vector indexed by phase number.
    always_comb begin
        demand       = {Tbl, Tb, Tal, Ta};
        own_demand   = demand[phase_q];
        other_demand = |(demand & ~(4'b0001 << phase_q));
    end

    // Round-robin search starting after the last-served phase; it is searched last.
    always_comb begin
        logic [1:0] cand;
        grant_vld = 1'b0;
        grant     = phase_q;
        cand      = phase_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = phase_q + 2'(k);
            if (!grant_vld && demand[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    // Next-state logic for the phase FSM and its dwell timer.
    always_comb begin
        fsm_d   = fsm_q;
        phase_d = phase_q;
        unique case (fsm_q)
            StAllRed: begin
                if (timer_q >= AllRedT && grant_vld) begin
                    fsm_d   = StGreen;
                    phase_d = grant;
                end
            end
            StGreen: begin
                if ((timer_q >= MinGreenT && !own_demand) ||
                    (timer_q >= MaxGreenT && other_demand)) begin
                    fsm_d = StYellow;
                end
            end
            StYellow: begin
                if (timer_q >= YellowT) begin
                    fsm_d = StAllRed;
                end
            end
            default: begin
                fsm_d = StAllRed;
            end
        endcase

        // Timer counts cycles in the current state, restarting at 1 on entry.
        if (fsm_d != fsm_q) begin
            timer_d = TimerOne;
        end else if (timer_q == TimerMax) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TimerOne;
        end
    end

    // State registers; reset parks in all-red with phase 3 so P0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= StAllRed;
            phase_q <= 2'd3;
            timer_q <= TimerOne;
        end else begin
            fsm_q   <= fsm_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        La          = LightRed;
        Lb          = LightRed;
        phase       = phase_q;
        phase_start = 1'b0;
        unique case (fsm_q)
            StGreen: begin
                phase_start = (timer_q == TimerOne);
                unique case (phase_q)
                    2'd0:    La = LightGreen;
                    2'd1:    La = LightLeft;
                    2'd2:    Lb = LightGreen;
                    default: Lb = LightLeft;
                endcase
            end
            StYellow: begin
                if (!phase_q[1]) begin
                    La = LightYellow;
                end else begin
                    Lb = LightYellow;
                end
            end
            default: begin
                La = LightRed;
                Lb = LightRed;
            end
        endcase
    end

endmodule
